// File: rtl/knn_pkg.sv
// Shared KNN constants, sequencer state encoding and the packed point layout.
// Defaults here feed the parameter defaults of knn_seq.
package knn_pkg;

  localparam int KNN_DATA_W   = 32;
  localparam int KNN_ADDR_W   = 10;
  localparam int KNN_PIPE_LAT = 4;
  localparam int KNN_COORD_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } knn_state_t;

  typedef struct packed {
    logic [KNN_COORD_W-1:0] y;
    logic [KNN_COORD_W-1:0] x;
  } knn_point_t;

endpackage

// File: rtl/knn_seq.sv
// KNN run sequencer: clears the sorter, streams n dataset points with the query, drains PIPE_LAT cycles.
// Latency: dp_valid one cycle after each read, done at n+PIPE_LAT+3; no backpressure, abort stops a run at once.
module knn_seq
  import knn_pkg::*;
#(
  parameter int DATA_W   = KNN_DATA_W,
  parameter int ADDR_W   = KNN_ADDR_W,
  parameter int PIPE_LAT = KNN_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   n_points,
  input  logic [DATA_W-1:0] test_point,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dp_clr,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_a,
  output logic [DATA_W-1:0] dp_b,
  output logic [ADDR_W-1:0] dp_idx,
  output logic              busy,
  output logic              done,
  output logic [31:0]       run_cycles
);

  localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam int DRAIN_W = $clog2(PIPE_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT);

  knn_state_t state, state_nxt;

  logic [ADDR_W:0]   n_lat;
  logic [ADDR_W:0]   n_clamp;
  logic [DATA_W-1:0] tp_lat;
  logic [ADDR_W-1:0] addr_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic              rd_q;
  logic [ADDR_W-1:0] idx_q;
  logic              launch;
  logic              last_addr;

  assign n_clamp   = (n_points > N_MAX) ? N_MAX : n_points;
  assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_addr = (({1'b0, addr_cnt} + (ADDR_W+1)'(1)) == n_lat);

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    dp_clr    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        dp_clr = 1'b1;
        busy   = 1'b1;
        if (abort)               state_nxt = ST_IDLE;
        else if (n_lat == '0)    state_nxt = ST_DONE;
        else                     state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        if (abort)          state_nxt = ST_IDLE;
        else if (last_addr) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (abort)                        state_nxt = ST_IDLE;
        else if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      n_lat      <= '0;
      tp_lat     <= '0;
      addr_cnt   <= '0;
      drain_cnt  <= '0;
      rd_q       <= 1'b0;
      idx_q      <= '0;
      run_cycles <= '0;
    end else begin
      state <= state_nxt;

      if (launch) begin
        tp_lat     <= test_point;
        n_lat      <= n_clamp;
        run_cycles <= '0;
      end else if (busy && (run_cycles != '1)) begin
        run_cycles <= run_cycles + 32'd1;
      end

      // Address parks on n-1 once issued, so it can never wrap past N_MAX-1.
      if (state != ST_FETCH)
        addr_cnt <= '0;
      else if (!last_addr && !abort)
        addr_cnt <= addr_cnt + ADDR_W'(1);

      if (state == ST_DRAIN)
        drain_cnt <= drain_cnt + DRAIN_W'(1);
      else
        drain_cnt <= '0;

      // A read issued in the abort cycle must not surface as dp_valid.
      rd_q  <= mem_rd && !abort;
      idx_q <= mem_addr;
    end
  end

  assign mem_addr = addr_cnt;
  assign dp_valid = rd_q;
  assign dp_idx   = idx_q;
  assign dp_a     = tp_lat;
  assign dp_b     = rd_q ? mem_rdata : '0;

endmodule
